serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first full subtractor with a registered borrow chain.
- Computes diff = a - b - bin over WIDTH clock cycles using one 1-bit full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart to the team's combinational full adder.
- Used in area-constrained datapaths where a WIDTH-bit ripple subtractor is too large; start/busy/done handshake to the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- diff  output  WIDTH  registered result a - b - bin (mod 2^WIDTH).
- bout  output  1  registered borrow-out; 1 when a < b + bin (unsigned).
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - asserting rst_n=0 immediately forces state=IDLE and clears all registers.
  - Outputs reset to diff=0, bout=0, busy=0, done=0; internal operand/shift registers, borrow FF and bit counter also cleared.
  - Reset mid-operation aborts; no done pulse is issued for the aborted op.
- States: IDLE, SHIFT, DONE (registered FSM).
- IDLE:
  - start=1 at edge k: a_sr<=a, b_sr<=b, borrow<=bin, cnt<=0, state<=SHIFT.
  - start=0: remain.
- SHIFT, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - a_sr, b_sr shift right 1.
  - d shifts into res_sr MSB (res_sr shifts right).
  - cnt <= cnt + 1.
- SHIFT completion: on the edge where cnt == WIDTH-1 (bit WIDTH-1 processed):
  - diff <= {d, res_sr[WIDTH-1:1]}; bout <= next borrow; done <= 1; state <= DONE.
- DONE: next edge: done <= 0, state <= IDLE.
- Latency: start accepted at edge k -> done high between edges k+WIDTH and k+WIDTH+1. Next start accepted no earlier than edge k+WIDTH+2.
- start in SHIFT/DONE is ignored (not queued); a, b, bin may change freely while busy.
- diff/bout update only at completion and hold until the next completion; no intermediate values visible on diff.
- busy = (state != IDLE), registered-state decode.
- cnt is ceil(log2(WIDTH)) bits; no wrap beyond WIDTH-1.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), reset 0.
  - ovf is the signed two's-complement overflow of a - b: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). a[MSB] and b[MSB] are taken from the last shifted-out operand bits.
  - ovf is registered with diff at completion and holds likewise.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- Reset then start with a=100, b=37, bin=0 (WIDTH=8) -> done pulses exactly 8 cycles after the start edge, lasting 1 cycle; diff=63, bout=0; busy high 9 cycles.
- a=5, b=9, bin=0 -> diff=252, bout=1. Then a=0, b=0, bin=1 -> diff=255, bout=1.
- a=255, b=255, bin=1 -> diff=255, bout=1. Back-to-back: second start held continuously is accepted at the first edge with state=IDLE, 10 cycles after the first.
- Pulse start again 3 cycles into an op with a=1, b=1 -> ignored; first result (e.g. 100-37=63) unaffected, only one done.
- Assert rst_n=0 mid-SHIFT (cycle 4) -> diff=0, bout=0, busy=0 immediately; no done; a new op after release completes correctly.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x10, b=0x01 -> diff=0x0F, ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles, start/busy/done handshake.
// Optional SERIAL_SUB_OVF_EN adds a registered signed-overflow output (ovf).
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// SHIFT | one bit per cycle through the full-subtractor cell
// DONE  | one-cycle done pulse, result already on diff/bout
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic d_bit;
    logic borrow_nx;
    logic last_bit;

    assign d_bit     = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    assign last_bit  = (state == SHIFT) && (cnt == CNT_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    borrow <= borrow_nx;
                    if (last_bit) begin
                        // result goes straight to diff so it appears with done, not a cycle later
                        diff  <= {d_bit, res_sr[WIDTH-1:1]};
                        bout  <= borrow_nx;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // a_sr[0]/b_sr[0] hold the operand sign bits on the last shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand sequences, random ops vs arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .diff (diff),
        .bout (bout),
        .busy (busy),
        .done (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow when the result goes negative
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int r;
        r  = int'(x) - int'(y) - int'(c);
        d  = r[W-1:0];
        bo = (r < 0);
        ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    endtask

    // One complete op; ign_at > 0 pulses a spurious start that many edges after acceptance
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] ediff, input logic ebout,
                          input int ign_at);
        logic [W-1:0] prev;
        int busy_cnt;
        int done_cnt;
        int done_at;
        int changed;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; bin = tbin;
        prev = diff;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        done_at  = -1;
        changed  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (i == ign_at) begin
                start = 1'b1; a = 8'd1; b = 8'd1; bin = 1'b0;
            end else if (i == ign_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (done_at < 0 && diff !== prev) changed = 1;
            if (busy) busy_cnt++;
            else if (!done) break;
        end
        chk({nm, "_latency"}, done_at, W);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_busy_cycles"}, busy_cnt, W + 1);
        chk({nm, "_diff_early"}, changed, 0);
        chk({nm, "_diff"}, diff, ediff);
        chk({nm, "_bout"}, bout, ebout);
    endtask

    initial begin
        vec_t tbl[8];
        logic [W-1:0] md;
        logic mbo;
        logic mov;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        int dn;
        int acc;
        int seen_idle;

        tbl[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
        tbl[1] = '{8'd5,   8'd9,   1'b0, 8'd252, 1'b1};
        tbl[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
        tbl[3] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
        tbl[4] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
        tbl[5] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
        tbl[6] = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0};
        tbl[7] = '{8'd37,  8'd37,  1'b0, 8'd0,   1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, 0);

        // Spurious start while shifting must not disturb the running op
        run_op("ignore", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 3);

        // Start held high: second op accepted at the first IDLE edge, 10 edges after the first
        @(negedge clk);
        start = 1'b1; a = 8'd255; b = 8'd255; bin = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd200; b = 8'd13; bin = 1'b0;
        dn = 0; acc = -1; seen_idle = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                if (dn == 1) begin
                    chk("b2b_diff1", diff, 255);
                    chk("b2b_bout1", bout, 1);
                end else begin
                    chk("b2b_diff2", diff, 187);
                    chk("b2b_bout2", bout, 0);
                end
            end
            if (!busy) seen_idle = 1;
            else if (seen_idle != 0 && acc < 0) begin
                acc = i;
                start = 1'b0;
            end
            if (dn >= 2 && !busy) break;
        end
        start = 1'b0;
        chk("b2b_accept", acc, 10);
        chk("b2b_dones", dn, 2);

        // Async reset in the middle of SHIFT
        run_op("pre_rst", 8'd200, 8'd50, 1'b0, 8'd150, 1'b0, 0);
        @(negedge clk);
        start = 1'b1; a = 8'd77; b = 8'd3; bin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_bout", bout, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        chk("mid_rst_no_done", dn, 0);
        run_op("post_rst", 8'd77, 8'd3, 1'b0, 8'd74, 1'b0, 0);

`ifdef SERIAL_SUB_OVF_EN
        run_op("ovf1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 0);
        chk("ovf1_ovf", ovf, 1);
        run_op("ovf0", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0);
        chk("ovf0_ovf", ovf, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, md, mbo, mov);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, md, mbo, 0);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), ovf, mov);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
